encoded_uart_tx: RTL and testbench

- Transmit-side serializer sitting directly downstream of the 8-bit encoder.
- Accepts one encoded byte per valid/ready handshake and drives it onto a single-wire line as a UART-style frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Feeds the channel/receiver side of the transmitter-receiver system.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/encoded_uart_tx_if.sv | 29 ++
 rtl/baud_counter.sv | 40 ++++
 rtl/encoded_uart_tx.sv | 140 ++++++++++++++
 tb/tb_encoded_uart_tx.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels.
// Used by the transmit serializer and, later, the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Even parity bit over one data byte.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/encoded_uart_tx_if.sv
// Byte handshake from the encoder plus serial line and status towards the channel.
interface encoded_uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_line;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_line,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_line,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/baud_counter.sv
// Bit-period counter: counts 0..BAUD_DIV-1, bit_end flags the last cycle of each period.
module baud_counter #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(BAUD_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end = (cnt_q == CNT_LAST);

  // Next count: held at zero while cleared, wraps on each bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/encoded_uart_tx.sv
// UART-style serializer for encoded bytes: start, 8 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module encoded_uart_tx #(
  parameter int BAUD_DIV = 16
) (
  input  logic               clk,
  input  logic               reset,
  encoded_uart_tx_if.slave   bus
);

  import uart_pkg::*;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       line_d, ready_d, busy_d, done_d;
  logic       clear_s, bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  // The bit timer only runs while a frame is on the line.
  assign clear_s = (state_q == IDLE);

  baud_counter #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_s),
    .bit_end (bit_end_s)
  );

  // Frame sequencing; outputs are derived from the next state so the registered line is cycle-aligned.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        idx_d = 3'd0;
        if (bus.tx_valid && bus.tx_ready) begin
          shift_d = bus.tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(bus.tx_data);
`endif
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    case (state_d)
      IDLE:    line_d = LINE_IDLE;
      START:   line_d = START_LEVEL;
      DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_d;
`endif
      STOP:    line_d = STOP_LEVEL;
      default: line_d = LINE_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      idx_q        <= 3'd0;
`ifdef UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
      bus.tx_line  <= LINE_IDLE;
      bus.tx_ready <= 1'b1;
      bus.tx_busy  <= 1'b0;
      bus.tx_done  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
`ifdef UART_TX_PARITY_EN
      par_q        <= par_d;
`endif
      bus.tx_line  <= line_d;
      bus.tx_ready <= ready_d;
      bus.tx_busy  <= busy_d;
      bus.tx_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_encoded_uart_tx.sv
// Directed bench for encoded_uart_tx at BAUD_DIV=4 and BAUD_DIV=1.
// Follows UART_TX_PARITY_EN to expect the parity bit when the feature is built in.
module tb_encoded_uart_tx;

  localparam int B0 = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  encoded_uart_tx_if bus0 ();
  encoded_uart_tx_if bus1 ();

  encoded_uart_tx #(.BAUD_DIV(B0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  encoded_uart_tx #(.BAUD_DIV(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {line, ready, busy, done}.
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] st0();
    return {bus0.tx_line, bus0.tx_ready, bus0.tx_busy, bus0.tx_done};
  endfunction

  function automatic logic [3:0] st1();
    return {bus1.tx_line, bus1.tx_ready, bus1.tx_busy, bus1.tx_done};
  endfunction

  // Entered one cycle after acceptance; seq lists data bits in line order. Ends on the tx_done cycle.
  task automatic frame_check(input logic [0:7] seq, input logic par, input string tag, input bit noise);
    int  nb;
    logic e;
    nb = 10 + PAR_BITS;
    for (int b = 0; b < nb; b++) begin
      if (b == 0) e = 1'b0;
      else if (b <= 8) e = seq[b-1];
      else if (b == 9 && PAR_BITS == 1) e = par;
      else e = 1'b1;
      for (int c = 0; c < B0; c++) begin
        if (noise && b == 2 && c == 1) begin
          bus0.tx_data  = 8'hFF;
          bus0.tx_valid = 1'b1;
        end
        check($sformatf("%s bit%0d cyc%0d", tag, b, c), st0(), {e, 3'b010});
        tick();
      end
    end
    check($sformatf("%s done", tag), st0(), 4'b1101);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus0.tx_data = 8'h00; bus0.tx_valid = 1'b0;
    bus1.tx_data = 8'h00; bus1.tx_valid = 1'b0;

    // Reset held, then released with no traffic.
    tick(); tick();
    check("in_reset0", st0(), 4'b1100);
    check("in_reset1", st1(), 4'b1100);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check($sformatf("idle%0d", i), st0(), 4'b1100);
    end
    check("idle_b1", st1(), 4'b1100);

    // Single frame 8'h5B, one-cycle valid.
    bus0.tx_data = 8'h5B; bus0.tx_valid = 1'b1;
    tick();
    bus0.tx_valid = 1'b0;
    frame_check(8'b11011010, 1'b1, "f5B", 1'b0);
    tick();
    check("f5B_done_clear", st0(), 4'b1100);

    // Back-to-back 8'h5B then 8'h73 with valid held.
    bus0.tx_data = 8'h5B; bus0.tx_valid = 1'b1;
    tick();
    bus0.tx_data = 8'h73;
    frame_check(8'b11011010, 1'b1, "b2b_5B", 1'b0);
    tick();
    bus0.tx_valid = 1'b0;
    frame_check(8'b11001110, 1'b1, "b2b_73", 1'b0);
    tick();
    check("b2b_idle", st0(), 4'b1100);

    // Data changed to 8'hFF mid-frame: ignored until the done cycle, then accepted.
    bus0.tx_data = 8'h5B; bus0.tx_valid = 1'b1;
    tick();
    bus0.tx_valid = 1'b0;
    frame_check(8'b11011010, 1'b1, "hold_5B", 1'b1);
    tick();
    bus0.tx_valid = 1'b0;
    frame_check(8'b11111111, 1'b0, "hold_FF", 1'b0);
    tick();
    check("hold_idle", st0(), 4'b1100);

    // Reset during data bit 3 (cycles 17..20 after acceptance).
    bus0.tx_data = 8'h5B; bus0.tx_valid = 1'b1;
    tick();
    bus0.tx_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("pre_rst_bit3", st0(), 4'b1010);
    reset = 1'b0;
    #1;
    check("async_rst", st0(), 4'b1100);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("post_rst%0d", i), st0(), 4'b1100);
    end
    bus0.tx_data = 8'h00; bus0.tx_valid = 1'b1;
    tick();
    bus0.tx_valid = 1'b0;
    frame_check(8'b00000000, 1'b0, "f00", 1'b0);
    tick();

    // BAUD_DIV=1, byte 8'h00: one bit per cycle.
    bus1.tx_data = 8'h00; bus1.tx_valid = 1'b1;
    tick();
    bus1.tx_valid = 1'b0;
    for (int i = 0; i < 9 + PAR_BITS; i++) begin
      check($sformatf("b1_low%0d", i), st1(), 4'b0010);
      tick();
    end
    check("b1_stop", st1(), 4'b1010);
    tick();
    check("b1_done", st1(), 4'b1101);
    tick();
    check("b1_idle", st1(), 4'b1100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
